// File: rtl/miso_fifo_pop_scheduler.sv
// miso_fifo_pop_scheduler
//   Drives a bank of NUM_FIFO MISO FIFOs feeding the PE-array rows. Pops are
//   issued with a systolic skew (FIFO k starts k cycles after FIFO 0). The
//   precision mode is latched and broadcast. End-of-pass is detected from the
//   FIFO empty flags. The bank is replayed for the programmed number of passes
//   by pulsing a read-pointer reset.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             start request, accepted only when idle
//   i_p_mode            precision mode, latched on accepted start
//   i_pass_count        number of passes, latched on start (0 runs one pass)
//   i_stall             backpressure; freezes pops and the skew ramp
//   i_fifo_empty        per-FIFO empty flags
//   o_pop_en            per-FIFO pop enable (combinational from state + inputs)
//   o_r_pointer_reset   read-pointer reset broadcast, one cycle per replay
//   o_p_mode            latched precision mode
//   o_pass_idx          current 0-based pass index
//   o_busy              high whenever not idle
//   o_done              one-cycle pulse at the end of the final pass
module miso_fifo_pop_scheduler #(
  parameter int NUM_FIFO   = 8,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_p_mode,
  input  logic [PASS_WIDTH-1:0] i_pass_count,
  input  logic                  i_stall,
  input  logic [NUM_FIFO-1:0]   i_fifo_empty,
  output logic [NUM_FIFO-1:0]   o_pop_en,
  output logic                  o_r_pointer_reset,
  output logic [1:0]            o_p_mode,
  output logic [PASS_WIDTH-1:0] o_pass_idx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int SKEW_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
  localparam logic [SKEW_W-1:0] SKEW_MAX = SKEW_W'(NUM_FIFO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS_END,
    S_PTR_RST,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [SKEW_W-1:0]     skew_q, skew_d;
  logic [PASS_WIDTH-1:0] pass_idx_q, pass_idx_d;
  logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic [1:0]            p_mode_q, p_mode_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rptr_q, rptr_d;

  logic [NUM_FIFO-1:0]   active;
  logic                  pass_end;
  logic                  more_passes;

  // Lane k joins the ramp once the skew counter has reached k.
  always_comb begin
    active = '0;
    for (int unsigned k = 0; k < NUM_FIFO; k++) begin
      active[k] = (32'(skew_q) >= k);
    end
  end

  assign o_pop_en = (state_q == S_RUN && !i_stall) ? (active & ~i_fifo_empty) : '0;

  // Ramp complete and every FIFO drained; stall does not hold this off.
  assign pass_end = (state_q == S_RUN) && (skew_q == SKEW_MAX) && (&i_fifo_empty);

  // One extra bit so pass_idx+1 cannot wrap at the maximum count.
  assign more_passes = ({1'b0, pass_idx_q} + {{PASS_WIDTH{1'b0}}, 1'b1}) < {1'b0, pass_cnt_q};

  always_comb begin
    state_d    = state_q;
    skew_d     = skew_q;
    pass_idx_d = pass_idx_q;
    pass_cnt_d = pass_cnt_q;
    p_mode_d   = p_mode_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          p_mode_d   = i_p_mode;
          pass_cnt_d = (i_pass_count == '0) ? PASS_WIDTH'(1) : i_pass_count;
          skew_d     = '0;
          pass_idx_d = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (pass_end) begin
          state_d = S_PASS_END;
        end else if (!i_stall && skew_q != SKEW_MAX) begin
          skew_d = skew_q + SKEW_W'(1);
        end
      end
      S_PASS_END: begin
        state_d = more_passes ? S_PTR_RST : S_DONE;
      end
      S_PTR_RST: begin
        pass_idx_d = pass_idx_q + PASS_WIDTH'(1);
        skew_d     = '0;
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered off the next state so they align with the state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    rptr_d = (state_d == S_PTR_RST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      skew_q     <= '0;
      pass_idx_q <= '0;
      pass_cnt_q <= '0;
      p_mode_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rptr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skew_q     <= skew_d;
      pass_idx_q <= pass_idx_d;
      pass_cnt_q <= pass_cnt_d;
      p_mode_q   <= p_mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rptr_q     <= rptr_d;
    end
  end

  assign o_r_pointer_reset = rptr_q;
  assign o_p_mode          = p_mode_q;
  assign o_pass_idx        = pass_idx_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;

endmodule

// File: tb/tb_miso_fifo_pop_scheduler.sv
// tb_miso_fifo_pop_scheduler
//   Directed bench for miso_fifo_pop_scheduler with NUM_FIFO=4. A small FIFO
//   occupancy model drives i_fifo_empty. Expected output events (pops,
//   pointer resets, done) are queued by the stimulus and compared by a
//   monitor whenever the DUT shows activity.
module tb_miso_fifo_pop_scheduler;

  localparam int NF = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stall;
  logic          load;
  logic [1:0]    p_mode;
  logic [PW-1:0] pass_count;
  logic [NF-1:0] fifo_empty;
  logic [NF-1:0] pop_en;
  logic          rptr;
  logic [1:0]    o_pm;
  logic [PW-1:0] pidx;
  logic          busy;
  logic          done;

  int depth = 0;
  int cnt  [NF];
  int pops [NF];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int            cyc;
    logic [NF-1:0] pop;
    logic          rptr;
    logic          done;
    logic [PW-1:0] pidx;
    logic [1:0]    pm;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  miso_fifo_pop_scheduler #(
    .NUM_FIFO  (NF),
    .PASS_WIDTH(PW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_p_mode         (p_mode),
    .i_pass_count     (pass_count),
    .i_stall          (stall),
    .i_fifo_empty     (fifo_empty),
    .o_pop_en         (pop_en),
    .o_r_pointer_reset(rptr),
    .o_p_mode         (o_pm),
    .o_pass_idx       (pidx),
    .o_busy           (busy),
    .o_done           (done)
  );

  // FIFO occupancy model: reload on reset/load/pointer reset, drain on pop.
  always_comb begin
    fifo_empty = '0;
    for (int k = 0; k < NF; k++) fifo_empty[k] = (cnt[k] == 0);
  end

  always @(posedge clk) begin
    for (int k = 0; k < NF; k++) begin
      if (load) pops[k] <= 0;
      else if (!rst && pop_en[k]) pops[k] <= pops[k] + 1;
      if (rst || load || rptr) cnt[k] <= depth;
      else if (pop_en[k]) cnt[k] <= cnt[k] - 1;
    end
  end

  // Monitor: any visible activity must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (pop_en != '0 || rptr || done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected cyc=%0d pop=%b rptr=%b done=%b", cyc, pop_en, rptr, done);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.pop != pop_en || e.rptr != rptr || e.done != done ||
            e.pidx != pidx || e.pm != o_pm) begin
          errors++;
          $display("FAIL sb_event cyc got=%0d want=%0d pop got=%b want=%b rptr got=%b want=%b done got=%b want=%b pidx got=%0d want=%0d pmode got=%b want=%b",
                   cyc, e.cyc, pop_en, e.pop, rptr, e.rptr, done, e.done, pidx, e.pidx, o_pm, e.pm);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [NF-1:0] p, input logic r, input logic d,
                      input logic [PW-1:0] pi, input logic [1:0] pm);
    ev_t e;
    e.cyc = c; e.pop = p; e.rptr = r; e.done = d; e.pidx = pi; e.pm = pm;
    exp_q.push_back(e);
  endtask

  // Unstalled pass over 2-deep FIFOs: first pop at cycle 'base'.
  task automatic push_pass(input int base, input logic [PW-1:0] pi, input logic [1:0] pm);
    push(base,     4'b0001, 1'b0, 1'b0, pi, pm);
    push(base + 1, 4'b0011, 1'b0, 1'b0, pi, pm);
    push(base + 2, 4'b0110, 1'b0, 1'b0, pi, pm);
    push(base + 3, 4'b1100, 1'b0, 1'b0, pi, pm);
    push(base + 4, 4'b1000, 1'b0, 1'b0, pi, pm);
  endtask

  // Reload the FIFO model, then raise start in cycle 0; returns in cycle 1.
  task automatic begin_job(input int d, input logic [1:0] pm, input logic [PW-1:0] pc);
    depth = d;
    load  = 1'b1;
    tick();
    load       = 1'b0;
    cyc        = 0;
    start      = 1'b1;
    p_mode     = pm;
    pass_count = pc;
    tick();
    start      = 1'b0;
    p_mode     = 2'b11;
    pass_count = 8'd9;
  endtask

  task automatic wait_to(input int c);
    int n = 0;
    while (cyc < c && n < 500) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 200 && busy; n++) tick();
    check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    check({name, "_sb_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; load = 1'b0;
    p_mode = 2'b00; pass_count = '0;
    tick(); tick(); tick();
    check("rst_pop_en", 32'(pop_en), 32'd0);
    check("rst_rptr",   32'(rptr),   32'd0);
    check("rst_p_mode", 32'(o_pm),   32'd0);
    check("rst_pidx",   32'(pidx),   32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    rst = 1'b0;
    tick();

    // Single pass, 2 entries per FIFO.
    push_pass(1, 8'd0, 2'b00);
    push(8, 4'b0000, 1'b0, 1'b1, 8'd0, 2'b00);
    begin_job(2, 2'b00, 8'd1);
    check("s1_busy_c1", 32'(busy), 32'd1);
    wait_to(7);
    check("s1_pass_end_busy", 32'(busy), 32'd1);
    check("s1_pass_end_pop", 32'(pop_en), 32'd0);
    wait_to(9);
    check("s1_idle_busy", 32'(busy), 32'd0);
    check("s1_idle_done", 32'(done), 32'd0);
    wait_idle("s1");

    // Three passes with replay.
    push_pass(1, 8'd0, 2'b00);
    push(8, 4'b0000, 1'b1, 1'b0, 8'd0, 2'b00);
    push_pass(10, 8'd1, 2'b00);
    push(17, 4'b0000, 1'b1, 1'b0, 8'd1, 2'b00);
    push_pass(19, 8'd2, 2'b00);
    push(26, 4'b0000, 1'b0, 1'b1, 8'd2, 2'b00);
    begin_job(2, 2'b00, 8'd3);
    wait_to(9);
    check("s2_pidx_settle", 32'(pidx), 32'd1);
    wait_idle("s2");
    for (int k = 0; k < NF; k++) check("s2_pops", 32'(pops[k]), 32'd6);

    // Stall on cycles 2-3.
    push(1, 4'b0001, 1'b0, 1'b0, 8'd0, 2'b00);
    push(4, 4'b0011, 1'b0, 1'b0, 8'd0, 2'b00);
    push(5, 4'b0110, 1'b0, 1'b0, 8'd0, 2'b00);
    push(6, 4'b1100, 1'b0, 1'b0, 8'd0, 2'b00);
    push(7, 4'b1000, 1'b0, 1'b0, 8'd0, 2'b00);
    push(10, 4'b0000, 1'b0, 1'b1, 8'd0, 2'b00);
    begin_job(2, 2'b00, 8'd1);
    wait_to(2);
    stall = 1'b1;
    wait_to(4);
    stall = 1'b0;
    wait_idle("s3");
    for (int k = 0; k < NF; k++) check("s3_pops", 32'(pops[k]), 32'd2);

    // Empty bank, pass count 0: no pops, RUN cycles 1-4, PASS_END 5, DONE 6.
    push(6, 4'b0000, 1'b0, 1'b1, 8'd0, 2'b00);
    begin_job(0, 2'b00, 8'd0);
    wait_idle("s4");

    // Reset mid-run, then an immediate restart in cycle 4.
    push(1, 4'b0001, 1'b0, 1'b0, 8'd0, 2'b10);
    push(2, 4'b0011, 1'b0, 1'b0, 8'd0, 2'b10);
    push(3, 4'b0110, 1'b0, 1'b0, 8'd0, 2'b10);
    push_pass(5, 8'd0, 2'b01);
    push(12, 4'b0000, 1'b0, 1'b1, 8'd0, 2'b01);
    begin_job(2, 2'b10, 8'd2);
    wait_to(3);
    rst = 1'b1;
    tick();
    check("s5_rst_pop_en", 32'(pop_en), 32'd0);
    check("s5_rst_rptr",   32'(rptr),   32'd0);
    check("s5_rst_p_mode", 32'(o_pm),   32'd0);
    check("s5_rst_busy",   32'(busy),   32'd0);
    check("s5_rst_done",   32'(done),   32'd0);
    rst        = 1'b0;
    start      = 1'b1;
    p_mode     = 2'b01;
    pass_count = 8'd1;
    tick();
    start = 1'b0;
    check("s5_restart_busy", 32'(busy), 32'd1);
    wait_idle("s5");

    // Start and new mode while busy are ignored.
    push_pass(1, 8'd0, 2'b01);
    push(8, 4'b0000, 1'b0, 1'b1, 8'd0, 2'b01);
    begin_job(2, 2'b01, 8'd1);
    wait_to(2);
    start      = 1'b1;
    p_mode     = 2'b10;
    pass_count = 8'd5;
    tick();
    start = 1'b0;
    while (cyc <= 8) begin
      check("s6_p_mode_hold", 32'(o_pm), 32'd1);
      tick();
    end
    wait_idle("s6");
    tick();
    check("s6_no_restart", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
